instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 32-bit word RAM (16-bit address line) and downstream of nothing but reset and branch redirects.
- Drives the RAM address with a program counter and samples the RAM's combinational read data.
- Buffers fetched words in a small FIFO and presents them to decode via a valid/ready handshake.
- Handles back-pressure, stall (fetch_enable low) and PC redirect with flush.

Parameters:
- ADDR_WIDTH, 16, RAM word-address width; PC width.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_enable  in  1  1 = fetch permitted this cycle.
- redirect_valid  in  1  1 = replace PC and flush buffer this cycle.
- redirect_pc  in  ADDR_WIDTH  new PC when redirect_valid = 1.
- ram_address  out  ADDR_WIDTH  RAM address; equals the current PC.
- ram_is_write  out  1  RAM write enable; constant 0.
- ram_in  out  DATA_WIDTH  RAM write data; constant 0.
- ram_out  in  DATA_WIDTH  RAM read data; combinational function of ram_address.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr  out  DATA_WIDTH  instruction word at FIFO head.
- instr_pc  out  ADDR_WIDTH  address the head word was fetched from.
- instr_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset is synchronous and active-high on clk; there is one clock.
- While reset = 1 at a rising edge:
  - pc <= RESET_PC; FIFO count <= 0; read and write pointers <= 0.
  - Outputs after that edge: instr_valid = 0, instr = 0, instr_pc = 0, ram_address = RESET_PC.
  - Reset overrides redirect, push and pop in the same cycle.
- Combinational signals:
  - ram_address = pc; ram_is_write = 0; ram_in = 0.
  - instr_valid = (count != 0).
  - instr and instr_pc come from the FIFO head when valid, else 0.
  - pop = instr_valid & instr_ready.
  - push = fetch_enable & ~redirect_valid & ((count < FIFO_DEPTH) | pop).
- Push: writes {pc, ram_out} at the tail and sets pc <= pc + 1. The PC is word-addressed and wraps 2^ADDR_WIDTH-1 -> 0.
- Pop: advances the head.
- Count update: count <= count + push - pop. Simultaneous push and pop on a full FIFO is legal and keeps count = FIFO_DEPTH.
- Redirect has priority over push:
  - pc <= redirect_pc; count <= 0; pointers <= 0.
  - A pop in the same cycle still counts as a completed transfer for decode; no other buffered entry survives.
  - Next cycle: instr_valid = 0 and ram_address = redirect_pc.
- Latency: a word fetched at edge N is visible as instr_valid = 1 after edge N, i.e. one cycle after the address was presented. Steady-state throughput is 1 word per cycle with instr_ready = 1.
- Back-pressure: while instr_valid = 1 and instr_ready = 0, instr and instr_pc stay stable. Fetching continues until the FIFO is full, after which pc holds.
- fetch_enable = 0: no push and pc holds. Pops continue.
- Empty FIFO with instr_ready = 1: no pop and no underflow.
- No combinational path from instr_ready to ram_address.

Decomposition:
- Shared package holds:
  - ADDR_WIDTH/DATA_WIDTH defaults, matching the RAM's 16-bit address and 32-bit data.
  - RESET_PC constant.
  - PC increment width rule.
- One sub-module, fetch_fifo: a synchronous FIFO of width ADDR_WIDTH+DATA_WIDTH and depth FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty, head.
- Top level holds the PC register and push/redirect logic.

Test Plan:
- Reset, then RAM preloaded mem[0..3] = 0xE5F84AB1, 0x5C8C6A01, 0x00000003, 0x00000004; fetch_enable = 1, instr_ready = 1 -> instr_valid rises one cycle after reset release; instr/instr_pc sequence is (0xE5F84AB1,0), (0x5C8C6A01,1), (3,2), (4,3) on consecutive cycles; ram_is_write is always 0.
- instr_ready = 0 for 5 cycles starting at pc 0 -> FIFO fills to 2; ram_address holds at 2; instr stays 0xE5F84AB1 / instr_pc 0 throughout. Raising ready resumes in order 0, 1, 2 with no loss or duplication.
- Redirect_valid pulsed with redirect_pc = 0xC3BC while the FIFO holds 2 entries -> next cycle instr_valid = 0 and ram_address = 0xC3BC; the following cycle instr_pc = 0xC3BC with instr = mem[0xC3BC].
- Redirect to 0xFFFE, free-run -> instr_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
- fetch_enable = 0 for 3 cycles mid-stream -> ram_address constant; buffered entries drain; instr_valid falls when count reaches 0.
- Reset asserted in the same cycle as redirect_valid and a push -> after the edge pc = RESET_PC, instr_valid = 0, instr = 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared defaults and helpers for the instruction fetch stage.
package instr_fetch_unit_pkg;

    localparam int unsigned IFU_ADDR_WIDTH = 16;
    localparam int unsigned IFU_DATA_WIDTH = 32;
    localparam int unsigned IFU_RESET_PC   = 0;
    localparam int unsigned IFU_FIFO_DEPTH = 2;

    // Word-addressed PC increment, truncated to the PC width so it wraps to 0.
    function automatic logic [31:0] pc_increment(input logic [31:0] pc, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (pc + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO buffering {pc, instruction} pairs between fetch and decode.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = IFU_ADDR_WIDTH + IFU_DATA_WIDTH,
    parameter int unsigned DEPTH = IFU_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Push+pop on a full FIFO overwrites the slot being popped; head is read before the edge.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= din;
    end

    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
        head  = mem[rd_ptr];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register driving a read-only RAM port, buffered into fetch_fifo for decode.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = IFU_DATA_WIDTH,
    parameter int unsigned RESET_PC   = IFU_RESET_PC,
    parameter int unsigned FIFO_DEPTH = IFU_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_enable,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_is_write,
    output logic [DATA_WIDTH-1:0] ram_in,
    input  logic [DATA_WIDTH-1:0] ram_out,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [EW-1:0]         head;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({pc, ram_out}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        ram_address  = pc;
        ram_is_write = 1'b0;
        ram_in       = '0;
        instr_valid  = !empty;
        instr        = instr_valid ? head[DATA_WIDTH-1:0] : '0;
        instr_pc     = instr_valid ? head[EW-1 -: ADDR_WIDTH] : '0;
        pop          = instr_valid && instr_ready;
        // A pop frees a slot in the same cycle, so a full FIFO can still accept a word.
        push         = fetch_enable && !redirect_valid && (!full || pop);
        pc_inc       = ADDR_WIDTH'(pc_increment(32'(pc), ADDR_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= ADDR_WIDTH'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc_inc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model plus directed literal checks.
module tb_instr_fetch_unit;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_enable = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] ram_address;
    logic          ram_is_write;
    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [65536];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_enable   (fetch_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ram_address    (ram_address),
        .ram_is_write   (ram_is_write),
        .ram_in         (ram_in),
        .ram_out        (ram_out),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    assign ram_out = mem[ram_address];

    function automatic logic [DW-1:0] mem_pattern(input logic [AW-1:0] a);
        return {a, ~a} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue of {pc, word}; pc is a plain wrapping counter.
    logic [AW+DW-1:0] mq[$];
    logic [AW-1:0]    mpc = '0;

    always @(posedge clk) begin
        bit m_pop, m_push;
        if (reset) begin
            mq.delete();
            mpc = '0;
        end else begin
            m_pop  = (mq.size() != 0) && instr_ready;
            m_push = fetch_enable && !redirect_valid && ((mq.size() < DEPTH) || m_pop);
            if (redirect_valid) begin
                mq.delete();
                mpc = redirect_pc;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back({mpc, mem[mpc]});
                    mpc = mpc + 1'b1;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("model_valid", 64'(instr_valid), 64'(mq.size() != 0));
            check("model_instr", 64'(instr), (mq.size() != 0) ? 64'(mq[0][DW-1:0]) : 64'd0);
            check("model_instr_pc", 64'(instr_pc), (mq.size() != 0) ? 64'(mq[0][AW+DW-1:DW]) : 64'd0);
            check("model_ram_address", 64'(ram_address), 64'(mpc));
            check("ram_is_write", 64'(ram_is_write), 64'd0);
            check("ram_in", 64'(ram_in), 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic expect_head(input string name, input logic [DW-1:0] w, input logic [AW-1:0] p);
        check({name, "_valid"}, 64'(instr_valid), 64'd1);
        check({name, "_instr"}, 64'(instr), 64'(w));
        check({name, "_pc"}, 64'(instr_pc), 64'(p));
    endtask

    logic [15:0] ready_pat = 16'b1011_0011_1000_1101;
    logic [15:0] fe_pat    = 16'b1110_1111_0110_1111;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = mem_pattern(16'(i));
        mem[0] = 32'hE5F8_4AB1;
        mem[1] = 32'h5C8C_6A01;
        mem[2] = 32'h0000_0003;
        mem[3] = 32'h0000_0004;

        // Reset state
        cyc();
        cyc();
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", 64'(instr_pc), 64'd0);
        check("rst_ram_address", 64'(ram_address), 64'd0);

        // Free-running fetch
        reset = 1'b0; fetch_enable = 1'b1; instr_ready = 1'b1;
        cyc(); expect_head("run0", 32'hE5F8_4AB1, 16'd0);
        cyc(); expect_head("run1", 32'h5C8C_6A01, 16'd1);
        cyc(); expect_head("run2", 32'h0000_0003, 16'd2);
        cyc(); expect_head("run3", 32'h0000_0004, 16'd3);

        // Back-pressure from pc 0
        reset = 1'b1; cyc();
        reset = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            expect_head("bp_hold", 32'hE5F8_4AB1, 16'd0);
            if (i >= 1) check("bp_ram_address", 64'(ram_address), 64'd2);
        end
        instr_ready = 1'b1;
        cyc(); expect_head("bp_resume1", 32'h5C8C_6A01, 16'd1);
        cyc(); expect_head("bp_resume2", 32'h0000_0003, 16'd2);

        // Redirect with a full buffer
        instr_ready = 1'b0;
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 16'hC3BC;
        cyc();
        check("redir_valid", 64'(instr_valid), 64'd0);
        check("redir_ram_address", 64'(ram_address), 64'h C3BC);
        redirect_valid = 1'b0; instr_ready = 1'b1;
        cyc(); expect_head("redir_head", mem_pattern(16'hC3BC), 16'hC3BC);

        // Wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        cyc();
        redirect_valid = 1'b0;
        cyc(); expect_head("wrap0", mem_pattern(16'hFFFE), 16'hFFFE);
        cyc(); expect_head("wrap1", mem_pattern(16'hFFFF), 16'hFFFF);
        cyc(); expect_head("wrap2", 32'hE5F8_4AB1, 16'h0000);
        cyc(); expect_head("wrap3", 32'h5C8C_6A01, 16'h0001);

        // Stall: fill, then drain with fetch disabled
        instr_ready = 1'b0;
        cyc(); cyc();
        fetch_enable = 1'b0; instr_ready = 1'b1;
        cyc();
        check("stall_ram_address0", 64'(ram_address), 64'd3);
        expect_head("stall_drain", 32'h0000_0003, 16'd2);
        cyc();
        check("stall_ram_address1", 64'(ram_address), 64'd3);
        check("stall_valid1", 64'(instr_valid), 64'd0);
        cyc();
        check("stall_ram_address2", 64'(ram_address), 64'd3);
        check("stall_valid2", 64'(instr_valid), 64'd0);

        // Reset beats a simultaneous redirect and push
        fetch_enable = 1'b1; instr_ready = 1'b0;
        cyc();
        redirect_valid = 1'b1; redirect_pc = 16'h1234; reset = 1'b1;
        cyc();
        check("rstpri_ram_address", 64'(ram_address), 64'd0);
        check("rstpri_valid", 64'(instr_valid), 64'd0);
        check("rstpri_instr", 64'(instr), 64'd0);
        redirect_valid = 1'b0; reset = 1'b0;

        // Mixed ready/enable patterns, checked by the model only
        for (int i = 0; i < 48; i++) begin
            instr_ready  = ready_pat[i % 16];
            fetch_enable = fe_pat[(i * 3) % 16];
            redirect_valid = (i == 29);
            redirect_pc  = 16'h0100;
            cyc();
        end
        redirect_valid = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
